// File: rtl/multi_coso_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_coso_packer_if
// Purpose  : Sampler handshake, sender and status bundle for multi_coso_packer.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_coso_packer_if #(
    parameter int NCH        = 2,
    parameter int CSCntWidth = 16
);
    logic [NCH*CSCntWidth-1:0] CSCnt;
    logic [NCH-1:0]            CSReq;
    logic [NCH-1:0]            matched;
    logic [NCH-1:0]            CSAck;
    logic                      is_transmitting;
    logic                      transmit;
    logic [7:0]                tx_byte;
    logic                      overflow;
    logic                      alarm;

    modport master (
        output CSCnt, CSReq, matched, is_transmitting,
        input  CSAck, transmit, tx_byte, overflow, alarm
    );

    modport slave (
        input  CSCnt, CSReq, matched, is_transmitting,
        output CSAck, transmit, tx_byte, overflow, alarm
    );
endinterface
`default_nettype wire

// File: rtl/multi_coso_packer.sv
`default_nettype none
// ============================================================================
// Module   : multi_coso_packer
// Purpose  : Packs sampler LSBs into bytes, queues them and feeds a sender.
// Revision : 1.0 - initial release
// ============================================================================
module multi_coso_packer #(
    parameter int NCH          = 2,
    parameter int CSCntWidth   = 16,
    parameter int NBLSB        = 1,
    parameter int FIFODepthLog = 4,
    parameter int RCTCutoff    = 8
) (
    input  wire logic          clk,
    input  wire logic          n_reset,
    multi_coso_packer_if.slave bus
);
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DEPTH = 1 << FIFODepthLog;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_STROBE    = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [NCH-1:0]          r_ack;
    logic [CHW-1:0]          r_rr_start;
    logic [7:0]              r_acc;
    logic [3:0]              r_bitcnt;
    logic [7:0]              r_prev;
    logic [7:0]              r_rep;
    logic                    r_alarm;
    logic                    r_overflow;
    logic [7:0]              r_mem [DEPTH];
    logic [FIFODepthLog-1:0] r_wr_ptr;
    logic [FIFODepthLog-1:0] r_rd_ptr;
    logic [FIFODepthLog:0]   r_count;
    logic [1:0]              r_state;
    logic [1:0]              r_to_cnt;
    logic [7:0]              r_tx_byte;

    logic [NCH-1:0]          w_pending;
    logic [NCH-1:0]          w_grant_oh;
    logic                    w_grant_valid;
    logic [CHW-1:0]          w_grant_idx;
    logic [CSCntWidth-1:0]   w_sel_cnt;
    logic [15:0]             w_acc_wide;
    logic [7:0]              w_acc_next;
    logic [3:0]              w_cnt_sum;
    logic [7:0]              w_rep_next;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_wr_en;
    logic                    w_start;
    logic                    w_pop;
    logic                    w_transmit;
    logic [1:0]              w_state_next;

    // Round-robin search begins at the channel after the last one captured.
    assign w_pending = bus.CSReq & ~r_ack;

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_grant_oh    = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!w_grant_valid && w_pending[(int'(r_rr_start) + k) % NCH]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = CHW'((int'(r_rr_start) + k) % NCH);
            end
        end
        if (w_grant_valid) begin
            w_grant_oh[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_ack      <= '0;
            r_rr_start <= '0;
        end else begin
            r_ack <= w_grant_oh | (r_ack & bus.CSReq);
            if (w_grant_valid) begin
                r_rr_start <= (w_grant_idx == CHW'(NCH - 1)) ? '0 : w_grant_idx + 1'b1;
            end
        end
    end

    assign bus.CSAck = r_ack;

    // New bits enter at the top so the earliest sample ends up in bit 0.
    assign w_sel_cnt  = bus.CSCnt[w_grant_idx*CSCntWidth +: CSCntWidth];
    assign w_accept   = w_grant_valid & bus.matched[w_grant_idx];
    assign w_acc_wide = {8'(w_sel_cnt[NBLSB-1:0]), r_acc};
    assign w_acc_next = w_acc_wide[NBLSB +: 8];
    assign w_cnt_sum  = r_bitcnt + 4'(NBLSB);
    assign w_push     = w_accept & w_cnt_sum[3] & ~r_alarm;
    assign w_rep_next = (w_acc_next != r_prev) ? 8'd1 :
                        (r_rep == 8'hFF)       ? 8'hFF : r_rep + 8'd1;

    // Health test follows every completed byte, whether or not the FIFO has room.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_acc      <= '0;
            r_bitcnt   <= '0;
            r_prev     <= '0;
            r_rep      <= '0;
            r_alarm    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc    <= w_acc_next;
                r_bitcnt <= w_cnt_sum & 4'h7;
            end
            if (w_push) begin
                r_prev <= w_acc_next;
                r_rep  <= w_rep_next;
                if (w_rep_next == 8'(RCTCutoff)) begin
                    r_alarm <= 1'b1;
                end
                if (w_full) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign bus.alarm    = r_alarm;
    assign bus.overflow = r_overflow;

    // Full is judged before any same-cycle pop, so a push into a full FIFO drops.
    assign w_full  = (r_count == (FIFODepthLog + 1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_wr_en = w_push & ~w_full;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_acc_next;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_start = ~w_empty & ~bus.is_transmitting;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state  <= S_IDLE;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_to_cnt <= (r_state == S_WAIT_BUSY) ? r_to_cnt + 1'b1 : 2'd0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (w_start) w_state_next = S_STROBE;
            S_STROBE:    w_state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (bus.is_transmitting)    w_state_next = S_WAIT_DONE;
                else if (r_to_cnt == 2'd3)  w_state_next = S_IDLE;
            end
            S_WAIT_DONE: if (!bus.is_transmitting) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop      = 1'b0;
        w_transmit = 1'b0;
        case (r_state)
            S_IDLE:   w_pop      = w_start;
            S_STROBE: w_transmit = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_tx_byte <= '0;
        end else if (w_pop) begin
            r_tx_byte <= r_mem[r_rd_ptr];
        end
    end

    assign bus.transmit = w_transmit;
    assign bus.tx_byte  = r_tx_byte;
endmodule
`default_nettype wire

// File: tb/tb_multi_coso_packer.sv
`default_nettype none
// Random and directed stimulus for multi_coso_packer, scored against a
// byte-level model of sample packing, repetition alarm and the sender.
module tb_multi_coso_packer;
    localparam int NCH = 2;
    localparam int CW  = 16;
    localparam int NB  = 1;
    localparam int FDL = 4;
    localparam int RCT = 3;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    multi_coso_packer_if #(.NCH(NCH), .CSCntWidth(CW)) bus ();

    multi_coso_packer #(
        .NCH(NCH), .CSCntWidth(CW), .NBLSB(NB), .FIFODepthLog(FDL), .RCTCutoff(RCT)
    ) dut (
        .clk(clk),
        .n_reset(n_reset),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    bit         bitq [$];
    logic [7:0] m_prev;
    int         m_rep;
    bit         m_alarm;

    int busy_left  = 0;
    int busy_len   = 0;
    bit busy_stuck = 1'b0;
    bit busy_clear = 1'b0;

    logic [1:0] rr_req [12] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00,
                                2'b01, 2'b00, 2'b11, 2'b11, 2'b00};
    logic [1:0] rr_exp [12] = '{2'b01, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00,
                                2'b01, 2'b00, 2'b10, 2'b11, 2'b00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Sender model: records each strobe and answers with a random busy pulse
    // (sometimes none, to exercise the timeout path).
    initial begin
        bus.is_transmitting = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.transmit === 1'b1) begin
                rx_q.push_back(bus.tx_byte);
                if (busy_len != 0)                busy_left = busy_len;
                else if ($urandom_range(0, 3) != 0) busy_left = int'($urandom_range(1, 6));
                else                              busy_left = 0;
            end else if (busy_left > 0) begin
                busy_left--;
            end
            if (busy_clear) busy_left = 0;
            bus.is_transmitting = busy_stuck || (busy_left > 0);
        end
    end

    task automatic model_reset();
        rx_q.delete();
        exp_q.delete();
        bitq.delete();
        m_prev  = '0;
        m_rep   = 0;
        m_alarm = 1'b0;
    endtask

    task automatic model_sample(input logic [CW-1:0] v, input bit m);
        logic [7:0] b;
        if (!m) return;
        for (int k = 0; k < NB; k++) bitq.push_back(v[k]);
        if (bitq.size() >= 8) begin
            b = '0;
            for (int k = 0; k < 8; k++) b[k] = bitq[k];
            repeat (8) void'(bitq.pop_front());
            if (!m_alarm) begin
                if (m_rep > 0 && b == m_prev) m_rep = (m_rep == 255) ? 255 : m_rep + 1;
                else                          m_rep = 1;
                m_prev = b;
                if (m_rep >= RCT) m_alarm = 1'b1;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic do_reset();
        busy_clear  = 1'b1;
        busy_stuck  = 1'b0;
        busy_len    = 0;
        bus.CSReq   = '0;
        bus.matched = '0;
        bus.CSCnt   = '0;
        n_reset     = 1'b0;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        busy_clear = 1'b0;
        model_reset();
    endtask

    // One full four-phase handshake on a single channel; starts and ends on a negedge.
    task automatic send_sample(input int ch, input logic [CW-1:0] v, input bit m);
        int n;
        bus.CSCnt[ch*CW +: CW] = v;
        bus.matched[ch]        = m;
        bus.CSReq[ch]          = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.CSAck[ch] !== 1'b1 && n < 8);
        check("ack_latency", n, 1);
        model_sample(v, m);
        bus.CSReq[ch] = 1'b0;
        @(negedge clk);
        check("ack_fall", bus.CSAck[ch], 1'b0);
    endtask

    task automatic send_bit(input int ch, input bit b, input bit m);
        logic [CW-1:0] v;
        v    = CW'($urandom);
        v[0] = b;
        send_sample(ch, v, m);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(0, b[i], 1'b1);
    endtask

    task automatic drain_and_compare(input string tag);
        int t;
        t = 0;
        while (rx_q.size() < exp_q.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (40) @(negedge clk);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    endtask

    initial begin
        int t;
        logic [7:0] pat;
        bus.CSReq   = '0;
        bus.matched = '0;
        bus.CSCnt   = '0;
        n_reset     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_outputs", {bus.CSAck, bus.transmit, bus.tx_byte, bus.overflow, bus.alarm}, 32'd0);
        n_reset = 1'b1;
        @(negedge clk);

        // Arbitration: both requesting alternates ch0/ch1; after a lone ch0 grant ch1 goes first.
        for (int i = 0; i < 12; i++) begin
            bus.CSReq = rr_req[i];
            @(negedge clk);
            check($sformatf("rr_step%0d", i), bus.CSAck, rr_exp[i]);
        end

        // Single-channel packing of 1,0,1,1,0,0,1,0.
        pat = 8'b0100_1101;
        for (int i = 0; i < 8; i++) send_bit(0, pat[i], 1'b1);
        drain_and_compare("pack");
        if (rx_q.size() > 0) check("pack_literal", rx_q[0], 8'h4D);
        check("tx_byte_hold", bus.tx_byte, 8'h4D);

        // Unmatched channel is acknowledged but contributes nothing.
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            send_bit(0, pat[i], 1'b1);
            send_bit(1, 1'b1, 1'b0);
        end
        drain_and_compare("unmatched");
        if (rx_q.size() > 1) check("unmatched_literal", rx_q[1], 8'hA5);

        // Random traffic over both channels.
        for (int i = 0; i < 240; i++)
            send_sample(int'($urandom_range(0, 1)), CW'($urandom), ($urandom_range(0, 3) != 0));
        drain_and_compare("random");
        check("random_overflow", bus.overflow, 1'b0);
        check("random_alarm", bus.alarm, m_alarm);

        // Sender stuck busy: 16 bytes fit, the 17th is dropped.
        do_reset();
        busy_stuck = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 17; k++) begin
            send_byte(8'(k * 37 + 5));
            if (k == 15) check("ovf_before_full", bus.overflow, 1'b0);
        end
        check("ovf_set", bus.overflow, 1'b1);
        check("ovf_nothing_sent", rx_q.size(), 0);
        busy_stuck = 1'b0;
        t = 0;
        while (rx_q.size() < 16 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (60) @(negedge clk);
        check("ovf_sent_count", rx_q.size(), 16);
        for (int i = 0; i < 16 && i < rx_q.size(); i++)
            check($sformatf("ovf_byte%0d", i), rx_q[i], exp_q[i]);
        check("ovf_sticky", bus.overflow, 1'b1);

        // Repetition alarm on the third consecutive 0x00.
        do_reset();
        send_byte(8'h5A);
        send_byte(8'h00);
        send_byte(8'h00);
        check("rct_before", bus.alarm, 1'b0);
        send_byte(8'h00);
        check("rct_set", bus.alarm, 1'b1);
        send_byte(8'h00);
        send_byte(8'h3C);
        drain_and_compare("rct");
        check("rct_sticky", bus.alarm, 1'b1);

        // Reset while waiting on a long transmission with bytes queued and a partial byte.
        do_reset();
        busy_len = 1000;
        send_byte(8'h81);
        t = 0;
        while (rx_q.size() < 1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("rst_first_tx", rx_q.size(), 1);
        repeat (6) @(negedge clk);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1, 1'b1);
        check("rst_held", rx_q.size(), 1);
        #2 n_reset = 1'b0;
        busy_clear = 1'b1;
        #1 check("rst_async_clear", {bus.CSAck, bus.transmit, bus.tx_byte, bus.overflow, bus.alarm}, 32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        busy_clear = 1'b0;
        busy_len   = 0;
        model_reset();
        repeat (30) @(negedge clk);
        check("rst_no_tx", rx_q.size(), 0);
        check("rst_post_outputs", {bus.CSAck, bus.transmit, bus.tx_byte, bus.overflow, bus.alarm}, 32'd0);
        send_byte(8'h3C);
        drain_and_compare("rst_fresh");
        if (rx_q.size() > 0) check("rst_fresh_literal", rx_q[0], 8'h3C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
